// File: rtl/filter_packet_buffer.sv
// -----------------------------------------------------------------------------
// filter_packet_buffer
//
// Purpose
//   Multi-entry staging queue for the RX packet filter. Symbols are written
//   into an assembly entry at any offset (1..LANES per cycle). A commit pushes
//   the assembly entry and its SOP/Type/Length sideband into a DEPTH-deep FIFO.
//   The downstream RX stage pops the head entry with a valid/ready handshake.
//
// Optional feature (macro FILTER_BUFF_BYTE_CNT_EN)
//   When defined, adds o_Byte_Cnt. Each stored entry carries the highest
//   written slot index + 1 seen since the previous commit, saturating at
//   ENTRY_SYMBOLS. When undefined, the port and the per-entry counters are
//   absent and all other behaviour is unchanged.
//
// Ports
//   CLK, RST_L    clock (rising edge), synchronous active-low reset
//   i_Wr_EN       write i_Wr_Count symbols starting at slot i_Wr_Offset
//   i_Wr_Offset   first assembly slot written
//   i_Wr_Count    number of symbols to write (0..LANES)
//   i_Wr_Data     symbol k at [k*SYMBOL_WIDTH +: SYMBOL_WIDTH], symbol 0 in the MSBs
//   i_Commit      push assembly entry (merged with same-cycle write) + sideband
//   i_SOP/i_Type/i_Length  sideband captured on commit
//   i_Flush       discard FIFO contents, assembly entry and overflow flag
//   i_Ready       consumer accepts the head entry
//   o_Valid       head entry available
//   o_Data, o_SOP, o_Type, o_Length  head entry (0 while empty)
//   o_Level       occupied entries; o_Full / o_Empty derived from it
//   o_Overflow    sticky: dropped write symbol or rejected commit
//   o_Byte_Cnt    (optional) head entry written-extent count
//
// Handshake
//   A pop happens in every cycle where o_Valid && i_Ready (and no flush).
//   o_Valid depends only on registered state, never on i_Ready; the consumer
//   may raise or drop i_Ready freely. The head pointer advances on the next
//   clock edge after a pop.
// -----------------------------------------------------------------------------
module filter_packet_buffer #(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int LANES            = 32,
  parameter int ENTRY_SYMBOLS    = 32,
  parameter int DEPTH            = 4,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = $clog2(ENTRY_SYMBOLS)
) (
  input  logic                                    CLK,
  input  logic                                    RST_L,
  input  logic                                    i_Wr_EN,
  input  logic [SYMBOL_PTR_WIDTH-1:0]             i_Wr_Offset,
  input  logic [$clog2(LANES+1)-1:0]              i_Wr_Count,
  input  logic [0:LANES*SYMBOL_WIDTH-1]           i_Wr_Data,
  input  logic                                    i_Commit,
  input  logic                                    i_SOP,
  input  logic                                    i_Type,
  input  logic [PACKET_LENGTH-1:0]                i_Length,
  input  logic                                    i_Flush,
  input  logic                                    i_Ready,
  output logic                                    o_Valid,
  output logic [0:ENTRY_SYMBOLS*SYMBOL_WIDTH-1]   o_Data,
  output logic                                    o_SOP,
  output logic                                    o_Type,
  output logic [PACKET_LENGTH-1:0]                o_Length,
  output logic [$clog2(DEPTH+1)-1:0]              o_Level,
  output logic                                    o_Full,
  output logic                                    o_Empty,
`ifdef FILTER_BUFF_BYTE_CNT_EN
  output logic [$clog2(ENTRY_SYMBOLS+1)-1:0]      o_Byte_Cnt,
`endif
  output logic                                    o_Overflow
);

  localparam int DW    = ENTRY_SYMBOLS * SYMBOL_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef FILTER_BUFF_BYTE_CNT_EN
  localparam int CNT_W = $clog2(ENTRY_SYMBOLS + 1);
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:DW-1]              asm_q,   asm_d;
  logic [PTR_W-1:0]           head_q,  head_d;
  logic [PTR_W-1:0]           tail_q,  tail_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic                       ovf_q,   ovf_d;

  logic [0:DW-1]              mem_data_q [DEPTH];
  logic                       mem_sop_q  [DEPTH];
  logic                       mem_type_q [DEPTH];
  logic [PACKET_LENGTH-1:0]   mem_len_q  [DEPTH];

`ifdef FILTER_BUFF_BYTE_CNT_EN
  logic [CNT_W-1:0]           bc_q, bc_d;
  logic [CNT_W-1:0]           bc_wr;
  logic [CNT_W-1:0]           mem_bc_q   [DEPTH];
`endif

  // ---------------------------------------------------------------------------
  // Assembly write: the merged entry (asm_wr) is what a same-cycle commit
  // pushes, so a write and a commit in one cycle land in the same entry.
  // ---------------------------------------------------------------------------
  logic [0:DW-1] asm_wr;
  logic          wr_drop;

  always_comb begin
    int slot;
    asm_wr  = asm_q;
    wr_drop = 1'b0;
    slot    = 0;
    if (i_Wr_EN) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < int'(i_Wr_Count)) begin
          slot = int'(i_Wr_Offset) + k;
          if (slot < ENTRY_SYMBOLS) begin
            asm_wr[slot*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
              i_Wr_Data[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
          end else begin
            // Symbol falls past the end of the entry: dropped.
            wr_drop = 1'b1;
          end
        end
      end
    end
  end

`ifdef FILTER_BUFF_BYTE_CNT_EN
  // Running written extent: max(offset+count) over writes since the last
  // commit, clipped to the entry size because dropped symbols do not count.
  always_comb begin
    int hi;
    bc_wr = bc_q;
    hi    = 0;
    if (i_Wr_EN && (i_Wr_Count != '0)) begin
      hi = int'(i_Wr_Offset) + int'(i_Wr_Count);
      if (hi > ENTRY_SYMBOLS) hi = ENTRY_SYMBOLS;
      if (hi > int'(bc_q)) bc_wr = CNT_W'(hi);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic full, empty;
  logic pop, push_req, push;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  // Flush wins over everything, so it also suppresses pop and push.
  assign pop      = !empty && i_Ready && !i_Flush;
  assign push_req = i_Commit && !i_Flush;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    asm_d   = asm_wr;
    ovf_d   = ovf_q;
`ifdef FILTER_BUFF_BYTE_CNT_EN
    bc_d    = bc_wr;
`endif
    if (i_Flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
      asm_d   = '0;
      ovf_d   = 1'b0;
`ifdef FILTER_BUFF_BYTE_CNT_EN
      bc_d    = '0;
`endif
    end else begin
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
      // Commit always consumes the assembly entry, even when it is rejected.
      if (i_Commit) begin
        asm_d = '0;
`ifdef FILTER_BUFF_BYTE_CNT_EN
        bc_d  = '0;
`endif
      end
      if (wr_drop || (push_req && !push)) ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      asm_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
`ifdef FILTER_BUFF_BYTE_CNT_EN
      bc_q    <= '0;
`endif
    end else begin
      asm_q   <= asm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
`ifdef FILTER_BUFF_BYTE_CNT_EN
      bc_q    <= bc_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_sop_q[i]  <= 1'b0;
        mem_type_q[i] <= 1'b0;
        mem_len_q[i]  <= '0;
`ifdef FILTER_BUFF_BYTE_CNT_EN
        mem_bc_q[i]   <= '0;
`endif
      end
    end else if (push) begin
      mem_data_q[tail_q] <= asm_wr;
      mem_sop_q[tail_q]  <= i_SOP;
      mem_type_q[tail_q] <= i_Type;
      mem_len_q[tail_q]  <= i_Length;
`ifdef FILTER_BUFF_BYTE_CNT_EN
      mem_bc_q[tail_q]   <= bc_wr;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational read of the head entry, forced to 0 while empty so
  // stale storage of already-popped entries is never visible.
  // ---------------------------------------------------------------------------
  assign o_Valid    = !empty;
  assign o_Empty    = empty;
  assign o_Full     = full;
  assign o_Level    = level_q;
  assign o_Overflow = ovf_q;
  assign o_Data     = empty ? '0   : mem_data_q[head_q];
  assign o_SOP      = empty ? 1'b0 : mem_sop_q[head_q];
  assign o_Type     = empty ? 1'b0 : mem_type_q[head_q];
  assign o_Length   = empty ? '0   : mem_len_q[head_q];
`ifdef FILTER_BUFF_BYTE_CNT_EN
  assign o_Byte_Cnt = empty ? '0   : mem_bc_q[head_q];
`endif

endmodule

// File: tb/tb_filter_packet_buffer.sv
// -----------------------------------------------------------------------------
// tb_filter_packet_buffer
//   Directed bench for filter_packet_buffer with default parameters
//   (8-bit symbols, 32 lanes, 32-symbol entries, depth 4, 11-bit length).
//   Expected values are written out by hand in each step.
// -----------------------------------------------------------------------------
module tb_filter_packet_buffer;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_l;
  logic          wr_en;
  logic [4:0]    wr_off;
  logic [5:0]    wr_cnt;
  logic [0:255]  wr_data;
  logic          commit;
  logic          sop;
  logic          typ;
  logic [10:0]   len;
  logic          flush;
  logic          ready;

  logic          o_valid;
  logic [0:255]  o_data;
  logic          o_sop;
  logic          o_type;
  logic [10:0]   o_length;
  logic [2:0]    o_level;
  logic          o_full;
  logic          o_empty;
  logic          o_ovf;
`ifdef FILTER_BUFF_BYTE_CNT_EN
  logic [5:0]    o_bc;
`endif

  filter_packet_buffer dut (
    .CLK         (clk),
    .RST_L       (rst_l),
    .i_Wr_EN     (wr_en),
    .i_Wr_Offset (wr_off),
    .i_Wr_Count  (wr_cnt),
    .i_Wr_Data   (wr_data),
    .i_Commit    (commit),
    .i_SOP       (sop),
    .i_Type      (typ),
    .i_Length    (len),
    .i_Flush     (flush),
    .i_Ready     (ready),
    .o_Valid     (o_valid),
    .o_Data      (o_data),
    .o_SOP       (o_sop),
    .o_Type      (o_type),
    .o_Length    (o_length),
    .o_Level     (o_level),
    .o_Full      (o_full),
    .o_Empty     (o_empty),
`ifdef FILTER_BUFF_BYTE_CNT_EN
    .o_Byte_Cnt  (o_bc),
`endif
    .o_Overflow  (o_ovf)
  );

  int total = 0;
  int bad   = 0;

  // Advance one clock; sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entry with one byte in slot 0 and zeros elsewhere.
  function automatic logic [255:0] slot0(input logic [7:0] b);
    return {b, 248'h0};
  endfunction

  task automatic idle_inputs();
    wr_en  = 1'b0;
    wr_off = '0;
    wr_cnt = '0;
    wr_data = '0;
    commit = 1'b0;
    sop    = 1'b0;
    typ    = 1'b0;
    len    = '0;
    flush  = 1'b0;
    ready  = 1'b0;
  endtask

  // Commit with a merged single-symbol write at slot 0.
  task automatic commit_byte(input logic [7:0] b, input logic [10:0] l, input logic rdy);
    wr_en   = 1'b1;
    wr_off  = 5'd0;
    wr_cnt  = 6'd1;
    wr_data = slot0(b);
    commit  = 1'b1;
    len     = l;
    ready   = rdy;
    step();
    idle_inputs();
  endtask

  initial begin
    logic [7:0] b;

    // ---- 1: reset held 3 cycles with write and commit active ----
    idle_inputs();
    rst_l   = 1'b0;
    wr_en   = 1'b1;
    wr_cnt  = 6'd4;
    wr_data = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 224'h0};
    commit  = 1'b1;
    repeat (3) step();
    check("rst_empty", o_empty, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_level", o_level, 3'd0);
    check("rst_ovf",   o_ovf,   1'b0);
    check("rst_full",  o_full,  1'b0);
    check("rst_data",  o_data,  256'h0);
    rst_l = 1'b1;
    idle_inputs();
    step();
    check("post_rst_level", o_level, 3'd0);

    // ---- 2: four 1-symbol writes then commit ----
    for (int i = 0; i < 4; i++) begin
      b       = 8'hA0 + 8'(i);
      wr_en   = 1'b1;
      wr_off  = 5'(i);
      wr_cnt  = 6'd1;
      wr_data = slot0(b);
      step();
    end
    idle_inputs();
    check("wr_no_push", o_valid, 1'b0);
    commit = 1'b1;
    sop    = 1'b1;
    typ    = 1'b1;
    len    = 11'd4;
    step();
    idle_inputs();
    check("t2_valid", o_valid, 1'b1);
    check("t2_data",  o_data,  {8'hA0, 8'hA1, 8'hA2, 8'hA3, 224'h0});
    check("t2_sop",   o_sop,   1'b1);
    check("t2_type",  o_type,  1'b1);
    check("t2_len",   o_length, 11'd4);
    check("t2_level", o_level, 3'd1);
`ifdef FILTER_BUFF_BYTE_CNT_EN
    check("t2_bc", o_bc, 6'd4);
`endif
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t2_pop_empty", o_empty, 1'b1);

    // ---- 3: five commits with no pops -> full + overflow ----
    for (int i = 0; i < 5; i++) commit_byte(8'h10 + 8'(i), 11'(i + 1), 1'b0);
    check("t3_full",  o_full,  1'b1);
    check("t3_level", o_level, 3'd4);
    check("t3_ovf",   o_ovf,   1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t3_head_data", o_data, slot0(8'h10 + 8'(i)));
      check("t3_head_len",  o_length, 11'(i + 1));
`ifdef FILTER_BUFF_BYTE_CNT_EN
      check("t3_head_bc", o_bc, 6'd1);
`endif
      ready = 1'b1;
      step();
      ready = 1'b0;
    end
    check("t3_empty",      o_empty, 1'b1);
    check("t3_ovf_sticky", o_ovf,   1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_flush_ovf", o_ovf, 1'b0);

    // ---- 4: commit + pop while full ----
    for (int i = 0; i < 4; i++) commit_byte(8'h20 + 8'(i), 11'd7, 1'b0);
    check("t4_full", o_full, 1'b1);
    commit_byte(8'h24, 11'd9, 1'b1);
    check("t4_level", o_level, 3'd4);
    check("t4_ovf",   o_ovf,   1'b0);
    for (int i = 1; i < 5; i++) begin
      check("t4_order", o_data, slot0(8'h20 + 8'(i)));
      ready = 1'b1;
      step();
      ready = 1'b0;
    end
    check("t4_empty", o_empty, 1'b1);

    // ---- 5: write past end of entry ----
    wr_en   = 1'b1;
    wr_off  = 5'd30;
    wr_cnt  = 6'd4;
    wr_data = {8'h11, 8'h22, 8'h33, 8'h44, 224'h0};
    commit  = 1'b1;
    step();
    idle_inputs();
    check("t5_data",  o_data,  {240'h0, 8'h11, 8'h22});
    check("t5_ovf",   o_ovf,   1'b1);
    check("t5_level", o_level, 3'd1);
`ifdef FILTER_BUFF_BYTE_CNT_EN
    check("t5_bc", o_bc, 6'd32);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_empty", o_empty, 1'b1);
    check("t5_flush_ovf",   o_ovf,   1'b0);

    // ---- 6: flush with commit, partial assembly pending ----
    commit_byte(8'h31, 11'd1, 1'b0);
    commit_byte(8'h32, 11'd2, 1'b0);
    wr_en   = 1'b1;
    wr_off  = 5'd5;
    wr_cnt  = 6'd1;
    wr_data = slot0(8'h55);
    step();
    idle_inputs();
    check("t6_level_pre", o_level, 3'd2);
    flush  = 1'b1;
    commit = 1'b1;
    step();
    idle_inputs();
    check("t6_level", o_level, 3'd0);
    check("t6_empty", o_empty, 1'b1);
    commit = 1'b1;
    step();
    idle_inputs();
    check("t6_valid", o_valid, 1'b1);
    check("t6_data",  o_data,  256'h0);
    check("t6_level_post", o_level, 3'd1);
`ifdef FILTER_BUFF_BYTE_CNT_EN
    check("t6_bc", o_bc, 6'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
